// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, start + DATA_BITS (LSB first) + 1 stop.
// Ports: i_clk, i_rstn, i_rx line in; o_data/o_valid/i_ready word handshake;
//        o_frame_err, o_overrun one-cycle error pulses; o_busy = not idle.
module uart_rx #(
    parameter int DIV       = 868,
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(DIV / 2 - 1);
    localparam logic [IW-1:0] LAST   = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick;

    // Two-flop synchronizer; idle-high so reset does not look like a start bit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    assign tick   = (cnt == '0);
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            // Consume; a delivery below in the same cycle overrides this.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (state != IDLE) begin
                cnt <= tick ? RELOAD : cnt - CW'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                            if (!o_valid || i_ready) begin
                                o_data  <= shreg;
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            state       <= BRK;
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                BRK: begin
                    // Held-low line must return high before a new start is accepted.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIV=16, DATA_BITS=8.
// Drives framed bytes on i_rx and checks delivered words and error pulses.
module tb_uart_rx;

    localparam int DIV = 16;
    localparam int DB  = 8;

    logic          clk;
    logic          rstn;
    logic          rx;
    logic [DB-1:0] data;
    logic          valid;
    logic          ready;
    logic          ferr;
    logic          ovr;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int lat;

    logic [DB-1:0] exp_q[$];

    uart_rx #(.DIV(DIV), .DATA_BITS(DB)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_frame_err(ferr),
        .o_overrun  (ovr),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stopb);
        rx = 1'b0;
        wait_clk(DIV);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            wait_clk(DIV);
        end
        rx = stopb;
        wait_clk(DIV);
    endtask

    // Scoreboard and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (ferr && ovr) check("err_excl", 32'(ferr & ovr), 32'd0);
            if (ferr) ferr_cnt++;
            if (ovr) ovr_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", 32'(data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_word", 32'(data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rstn  = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;

        // Reset holds everything quiet even with a toggling line.
        for (int i = 0; i < 6; i++) begin
            rx = ~rx;
            wait_clk(3);
        end
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        wait_clk(2);
        rstn = 1'b1;
        wait_clk(20);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(valid), 32'd0);

        // Single word with latency measurement, held until ready.
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 400; n++) begin
                    wait_clk(1);
                    if (valid) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        check("a5_latency", 32'(lat), 32'(2 + DIV / 2 + (DB + 1) * DIV + 1));
        wait_clk(50);
        check("a5_hold_valid", 32'(valid), 32'd1);
        check("a5_hold_data", 32'(data), 32'hA5);
        ready = 1'b1;
        wait_clk(2);
        check("a5_consumed", 32'(valid), 32'd0);

        // Short glitch is rejected.
        rx = 1'b0;
        wait_clk(4);
        rx = 1'b1;
        wait_clk(30);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        check("glitch_valid", 32'(valid), 32'd0);

        // Framing error then held-low line.
        send_frame(8'h3C, 1'b0);
        wait_clk(40);
        check("fe_count", 32'(ferr_cnt), 32'd1);
        check("fe_valid", 32'(valid), 32'd0);
        check("fe_break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clk(5);
        check("fe_release_busy", 32'(busy), 32'd0);

        // Overrun: second word dropped, first kept.
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_clk(4);
        send_frame(8'h22, 1'b1);
        wait_clk(4);
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        check("ovr_data", 32'(data), 32'h11);
        check("ovr_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        wait_clk(3);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        wait_clk(20);
        check("ovr_after_33", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with ready held high.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        wait_clk(20);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        check("b2b_ferr", 32'(ferr_cnt), 32'd1);
        check("b2b_ovr", 32'(ovr_cnt), 32'd1);

        // Reset in the middle of the data bits leaves no word.
        rx = 1'b0;
        wait_clk(DIV);
        rx = 1'b1;
        wait_clk(DIV);
        rx = 1'b0;
        wait_clk(DIV);
        check("mid_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        rx = 1'b1;
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(200);
        check("mid_no_word", 32'(valid), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);
        check("final_q", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
